// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter with 4-entry FIFO, programmable baud divider and level interrupt
module uart_tx_periph #(
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        csb_i,
  input  logic        wen_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  wmask_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] fifo [4];
  logic [1:0] wr_ptr, rd_ptr, sel;
  logic [2:0] count, bit_idx;
  logic [15:0] bauddiv, bit_cnt;
  logic [7:0] shift;
  logic overrun, tx_en, irq_en, wr, busy, full, empty, push, pop, push_ok;
  assign sel = addr_i[3:2];
  assign wr = ~csb_i & ~wen_i;
  assign busy = state != IDLE;
  assign full = count == 3'd4;
  assign empty = count == 3'd0;
  assign push = wr && sel == 2'd0 && wmask_i[0];
  assign pop = state == IDLE && tx_en && !empty;
  assign push_ok = push && (!full || pop);
  assign irq_o = irq_en & empty & ~busy;
  // read mux, zero while deselected
  always_comb
    data_o = csb_i ? 32'd0 :
             sel == 2'd0 ? {full, 31'd0} :
             sel == 2'd1 ? {25'd0, count, overrun, empty, full, busy} :
             sel == 2'd2 ? {16'd0, bauddiv} : {30'd0, irq_en, tx_en};
  // FIFO storage, write-only on accepted pushes
  always_ff @(posedge clk_i)
    if (push_ok) fifo[wr_ptr] <= data_i[7:0];
  // FIFO bookkeeping and configuration registers
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overrun <= 1'b0;
      bauddiv <= DEFAULT_DIV;
      tx_en <= 1'b1;
      irq_en <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + 2'(push_ok);
      rd_ptr <= rd_ptr + 2'(pop);
      count <= count + 3'(push_ok) - 3'(pop);
      if (push && !push_ok) overrun <= 1'b1;
      else if (wr && sel == 2'd1 && wmask_i[0] && data_i[3]) overrun <= 1'b0;
      if (wr && sel == 2'd2 && wmask_i[0]) bauddiv[7:0] <= data_i[7:0];
      if (wr && sel == 2'd2 && wmask_i[1]) bauddiv[15:8] <= data_i[15:8];
      if (wr && sel == 2'd3 && wmask_i[0]) {irq_en, tx_en} <= data_i[1:0];
    end
  // transmit FSM; each bit reloads the counter from the divider current at its start
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state <= IDLE;
      tx_o <= 1'b1;
      shift <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          state <= START;
          tx_o <= 1'b0;
          shift <= fifo[rd_ptr];
          bit_cnt <= bauddiv;
        end
        START: if (bit_cnt == 16'd0) begin
          state <= DATA;
          tx_o <= shift[0];
          bit_cnt <= bauddiv;
          bit_idx <= 3'd0;
        end else bit_cnt <= bit_cnt - 16'd1;
        DATA: if (bit_cnt == 16'd0) begin
          bit_cnt <= bauddiv;
          if (bit_idx == 3'd7) begin
            state <= STOP;
            tx_o <= 1'b1;
          end else begin
            shift <= shift >> 1;
            tx_o <= shift[1];
            bit_idx <= bit_idx + 3'd1;
          end
        end else bit_cnt <= bit_cnt - 16'd1;
        STOP: if (bit_cnt == 16'd0) begin
          state <= IDLE;
          tx_o <= 1'b1;
        end else bit_cnt <= bit_cnt - 16'd1;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: register table plus scoreboard-checked serial frames and timing corner cases
module tb_uart_tx_periph;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic csb = 1'b1, wen = 1'b1;
  logic [3:0] addr = '0, wmask = '0;
  logic [31:0] wdata = '0, data_o, rd;
  logic tx_o, irq_o;
  int n_cmp = 0, n_err = 0;
  logic [7:0] sb [$];
  logic mon_on = 1'b1;
  int mon_div = 3;
  logic [7:0] mon_b, mon_e;
  typedef struct {
    bit wr;
    logic [3:0] addr;
    logic [31:0] data;
    logic [3:0] mask;
    logic [31:0] exp;
    bit sb;
  } vec_t;
  vec_t tbl [$];

  uart_tx_periph dut (
    .clk_i(clk), .reset_i(reset_i), .csb_i(csb), .wen_i(wen), .addr_i(addr),
    .data_i(wdata), .wmask_i(wmask), .data_o(data_o), .tx_o(tx_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void add(bit w, logic [3:0] a, logic [31:0] d, logic [3:0] m, logic [31:0] e, bit s);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.mask = m; v.exp = e; v.sb = s;
    tbl.push_back(v);
  endfunction

  task automatic bus_wr(logic [3:0] a, logic [31:0] d, logic [3:0] m);
    @(negedge clk);
    csb = 1'b0; wen = 1'b0; addr = a; wdata = d; wmask = m;
    @(posedge clk);
    #1 csb = 1'b1; wen = 1'b1;
  endtask

  task automatic bus_rd(logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    csb = 1'b0; wen = 1'b1; addr = a;
    #1 d = data_o;
    csb = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 800 && sb.size() != 0; i++) @(posedge clk);
    check("drain", sb.size(), 0);
    repeat (4) @(posedge clk);
  endtask

  // frame decoder sampling mid-bit on falling edges
  initial forever begin
    @(negedge clk);
    if (mon_on && reset_i && tx_o === 1'b0) begin
      repeat ((mon_div + 1) / 2) @(negedge clk);
      check("mon_start", {31'd0, tx_o}, 0);
      for (int k = 0; k < 8; k++) begin
        repeat (mon_div + 1) @(negedge clk);
        mon_b[k] = tx_o;
      end
      repeat (mon_div + 1) @(negedge clk);
      check("mon_stop", {31'd0, tx_o}, 1);
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL mon_unexpected: got byte %h expected none", mon_b);
      end else begin
        mon_e = sb.pop_front();
        check("mon_byte", {24'd0, mon_b}, {24'd0, mon_e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] fr;
    logic exp_q [$];
    int low;
    add(0, 4'h4, 0, 0, 32'h4, 0);
    add(0, 4'h8, 0, 0, 32'h363, 0);
    add(0, 4'hC, 0, 0, 32'h1, 0);
    add(0, 4'h0, 0, 0, 32'h0, 0);
    add(1, 4'hC, 32'h0, 4'h1, 0, 0);
    add(0, 4'hC, 0, 0, 32'h0, 0);
    add(1, 4'h8, 32'h1234, 4'h1, 0, 0);
    add(0, 4'h8, 0, 0, 32'h334, 0);
    add(1, 4'h8, 32'hAB00, 4'h2, 0, 0);
    add(0, 4'h8, 0, 0, 32'hAB34, 0);
    add(1, 4'h8, 32'hFFFF0003, 4'hF, 0, 0);
    add(0, 4'h8, 0, 0, 32'h3, 0);
    add(1, 4'hC, 32'hFF, 4'h0, 0, 0);
    add(0, 4'hE, 0, 0, 32'h0, 0);
    add(1, 4'h0, 32'h11, 4'h0, 0, 0);
    add(0, 4'h4, 0, 0, 32'h4, 0);
    for (int i = 1; i <= 4; i++) add(1, 4'h0, i, 4'h1, 0, 1);
    add(1, 4'h0, 32'h05, 4'h1, 0, 0);
    add(0, 4'h4, 0, 0, 32'h4A, 0);
    add(0, 4'h0, 0, 0, 32'h80000000, 0);
    add(1, 4'h4, 32'h0, 4'h1, 0, 0);
    add(0, 4'h7, 0, 0, 32'h4A, 0);
    add(1, 4'h4, 32'hF7, 4'h1, 0, 0);
    add(0, 4'h4, 0, 0, 32'h4A, 0);

    #2 reset_i = 1'b0;
    #1;
    check("rst_tx", {31'd0, tx_o}, 1);
    check("rst_irq", {31'd0, irq_o}, 0);
    addr = 4'hC;
    #1 check("rst_csb_data", data_o, 0);
    repeat (3) @(negedge clk);
    reset_i = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        if (tbl[i].sb) sb.push_back(tbl[i].data[7:0]);
        bus_wr(tbl[i].addr, tbl[i].data, tbl[i].mask);
      end else begin
        bus_rd(tbl[i].addr, rd);
        check($sformatf("tbl%0d", i), rd, tbl[i].exp);
      end
    end

    bus_wr(4'hC, 32'h1, 4'h1);
    drain();
    bus_rd(4'h4, rd);
    check("ovr_kept", rd, 32'hC);
    bus_wr(4'h4, 32'h8, 4'h1);
    bus_rd(4'h4, rd);
    check("ovr_clear", rd, 32'h4);

    fr = {1'b1, 8'hA5, 1'b0};
    sb.push_back(8'hA5);
    bus_wr(4'h0, 32'hA5, 4'h1);
    csb = 1'b0; wen = 1'b1; addr = 4'h4;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      check("a5_tx", {31'd0, tx_o}, {31'd0, fr[i / 4]});
      check("a5_busy", {31'd0, data_o[0]}, 1);
    end
    @(posedge clk);
    #1 check("a5_idle", {31'd0, data_o[0]}, 0);
    csb = 1'b1;
    drain();

    bus_wr(4'hC, 32'h3, 4'h1);
    #1 check("irq_idle", {31'd0, irq_o}, 1);
    sb.push_back(8'h3C);
    bus_wr(4'h0, 32'h3C, 4'h1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 check("irq_busy", {31'd0, irq_o}, 0);
    end
    @(posedge clk);
    #1 check("irq_done", {31'd0, irq_o}, 1);
    bus_wr(4'hC, 32'h1, 4'h1);
    drain();

    for (int i = 0; i < 5; i++) begin
      sb.push_back(8'h60 + 8'(i));
      bus_wr(4'h0, 32'h60 + i, 4'h1);
    end
    repeat (37) @(posedge clk);
    sb.push_back(8'h65);
    bus_wr(4'h0, 32'h65, 4'h1);
    bus_rd(4'h4, rd);
    check("full_pushpop", rd, 32'h43);
    drain();

    mon_on = 1'b0;
    for (int b = 0; b < 10; b++) begin
      fr = {1'b1, 8'h55, 1'b0};
      for (int c = 0; c < (b <= 3 ? 4 : 8); c++) exp_q.push_back(fr[b]);
    end
    bus_wr(4'h0, 32'h55, 4'h1);
    foreach (exp_q[i]) begin
      @(posedge clk);
      #1;
      if (i == 12) begin
        csb = 1'b0; wen = 1'b0; addr = 4'h8; wdata = 32'h7; wmask = 4'h3;
      end
      if (i == 13) begin
        csb = 1'b1; wen = 1'b1;
      end
      check("div_change_tx", {31'd0, tx_o}, {31'd0, exp_q[i]});
    end
    repeat (2) @(posedge clk);
    bus_wr(4'h8, 32'h3, 4'h3);

    for (int i = 0; i < 3; i++) bus_wr(4'h0, 32'h0, 4'h1);
    repeat (12) @(posedge clk);
    #2 check("pre_rst_tx", {31'd0, tx_o}, 0);
    reset_i = 1'b0;
    #1 check("rst_async_tx", {31'd0, tx_o}, 1);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    bus_rd(4'h4, rd);
    check("post_rst_status", rd, 32'h4);
    bus_rd(4'h8, rd);
    check("post_rst_div", rd, 32'd867);
    low = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1) low++;
    end
    check("post_rst_quiet", low, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
